ex_in_conditioner: RTL and testbench
====================================

EX_IN_CONDITIONER -- requirements
Module: ex_in_conditioner

Interface
REQ-001 Parameter FPGAClkSpeed, default 50000000, system clock frequency in Hz.
REQ-002 Parameter DebounceUs, default 1000, required input stability time in microseconds.
REQ-003 Parameter data_width, default 8, number of external input bits.
REQ-004 clk_i  input  1  single system clock; all logic on rising edge.
REQ-005 reset_i  input  1  asynchronous, active-high reset.
REQ-006 ex_data_i  input  data_width  raw asynchronous external pins.
REQ-007 clear_i  input  data_width  per-bit clear of sticky event flags, one-cycle pulse.
REQ-008 ex_data_o  output  data_width  synchronized, debounced level; drives main_6502 ex_data_i.
REQ-009 rise_o  output  data_width  one-cycle pulse per debounced 0->1 transition.
REQ-010 fall_o  output  data_width  one-cycle pulse per debounced 1->0 transition.
REQ-011 event_o  output  data_width  sticky per-bit "edge occurred" flags.
REQ-012 irq_o  output  1  OR-reduction of event_o.

Function
REQ-013 DEBOUNCE_CYCLES = (FPGAClkSpeed/1000000)*DebounceUs, minimum 1; counter width $clog2(DEBOUNCE_CYCLES+1).
REQ-014 Each bit: two-flop synchronizer (sync1, sync2) ahead of all other logic.
REQ-015 Each bit: states STABLE (sync2 == ex_data_o bit) and PENDING (sync2 != ex_data_o bit).
REQ-016 STABLE: counter held at 0.
REQ-017 PENDING: counter increments each cycle; on the cycle counter == DEBOUNCE_CYCLES-1, ex_data_o bit <= sync2 and counter <= 0.
REQ-018 Return to STABLE before terminal count (glitch): counter <= 0, ex_data_o unchanged.
REQ-019 Latency: pin change held steady -> ex_data_o changes exactly DEBOUNCE_CYCLES+2 rising edges after the first edge sampling the new value.
REQ-020 rise_o/fall_o registered; asserted in the same cycle ex_data_o bit takes its new value, for exactly one cycle.
REQ-021 Bits are fully independent; simultaneous transitions on multiple bits produce simultaneous pulses.
REQ-022 event_o bit set on rise or fall pulse; cleared by clear_i bit; set and clear same cycle -> set wins.
REQ-023 irq_o combinational OR of event_o; no extra latency.

Reset
REQ-024 reset_i asserted: sync1, sync2, counters, ex_data_o, rise_o, fall_o, event_o all 0 immediately, irrespective of clk_i.
REQ-025 Reset mid-debounce aborts the pending transition; no pulse generated on reset release.
REQ-026 Input held high through reset release -> ex_data_o rises DEBOUNCE_CYCLES+2 edges after release, with rise_o pulse.

Configuration
REQ-027 Macro EX_IN_EVENT_LATCH_EN defined: event_o, clear_i, irq_o behave per REQ-022/023.
REQ-028 Macro undefined: event_o and irq_o tied 0, clear_i ignored, no sticky flops synthesized; rise_o/fall_o unaffected.

Structure
REQ-029 Package ex_in_pkg holds debounce-cycle calculation function and per-bit state enum (STABLE, PENDING).
REQ-030 Sub-module ex_in_debounce_bit (synchronizer, counter, level, rise/fall) instantiated data_width times via generate; top holds sticky flags and irq.

Verification (bench: FPGAClkSpeed=1000000, DebounceUs=4 -> DEBOUNCE_CYCLES=4)
REQ-031 Bit0 0->1 held -> ex_data_o[0]=1 and rise_o[0] one-cycle pulse exactly 6 edges later; event_o[0]=1, irq_o=1.
REQ-032 Bit3 high for 3 cycles then low -> ex_data_o[3] stays 0, no rise/fall pulse, event_o[3]=0.
REQ-033 event_o[0]=1, clear_i[0] pulse coincident with new fall_o[0] -> event_o[0] remains 1; later clear alone -> 0, irq_o=0.
REQ-034 ex_data_i=8'hA5 applied at once -> ex_data_o=8'hA5, rise_o=8'hA5 in same cycle, fall_o=0.
REQ-035 reset_i asserted mid-PENDING (counter=2) between clock edges -> all outputs 0 immediately; after release with pin high, rise after 6 edges.
REQ-036 Build without EX_IN_EVENT_LATCH_EN, repeat REQ-031 -> rise_o pulse present, event_o=0, irq_o=0.

Source files
------------

// File: rtl/ex_in_pkg.sv
// Shared definitions for the external-input conditioner: debounce length
// calculation and the per-bit debounce state.
package ex_in_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_e;

  // Cycles an input must hold steady before the debounced level follows it.
  function automatic int debounce_cycles(input int clk_hz, input int us);
    int cycles;
    cycles = (clk_hz / 1000000) * us;
    return (cycles < 1) ? 1 : cycles;
  endfunction

endpackage

// File: rtl/ex_in_debounce_bit.sv
// One external input bit: two-flop synchronizer, stability counter, debounced
// level and registered rise/fall pulses.
module ex_in_debounce_bit
  import ex_in_pkg::*;
#(
  parameter int DebounceCycles = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] TermCnt = CntW'(DebounceCycles - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  db_state_e       state;

  always_comb begin
    state   = (sync2_q != level_q) ? PENDING : STABLE;
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (state == PENDING) begin
      if (cnt_q == TermCnt) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ex_in_conditioner.sv
// Conditions raw external pins into debounced levels, edge pulses and sticky
// event flags. Define EX_IN_EVENT_LATCH_EN to build event_o/irq_o/clear_i.
module ex_in_conditioner
  import ex_in_pkg::*;
#(
  parameter int FPGAClkSpeed = 50000000,
  parameter int DebounceUs   = 1000,
  parameter int data_width   = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [data_width-1:0] ex_data_i,
  input  logic [data_width-1:0] clear_i,
  output logic [data_width-1:0] ex_data_o,
  output logic [data_width-1:0] rise_o,
  output logic [data_width-1:0] fall_o,
  output logic [data_width-1:0] event_o,
  output logic                  irq_o
);

  localparam int DebounceCycles = debounce_cycles(FPGAClkSpeed, DebounceUs);

  for (genvar gi = 0; gi < data_width; gi++) begin : g_bit
    ex_in_debounce_bit #(
      .DebounceCycles(DebounceCycles)
    ) u_bit (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .pin_i   (ex_data_i[gi]),
      .level_o (ex_data_o[gi]),
      .rise_o  (rise_o[gi]),
      .fall_o  (fall_o[gi])
    );
  end

`ifdef EX_IN_EVENT_LATCH_EN
  logic [data_width-1:0] event_q, event_d;

  // A new edge beats a simultaneous clear so no event is ever lost.
  always_comb begin
    event_d = (event_q & ~clear_i) | rise_o | fall_o;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      event_q <= '0;
    end else begin
      event_q <= event_d;
    end
  end

  assign event_o = event_q;
  assign irq_o   = |event_q;
`else
  logic [data_width-1:0] unused_clear;
  assign unused_clear = clear_i;
  assign event_o      = '0;
  assign irq_o        = 1'b0;
`endif

endmodule

// File: tb/tb_ex_in_conditioner.sv
// Bench for ex_in_conditioner: directed scenarios plus randomized pin traffic
// checked every cycle against a run-length reference model.
module tb_ex_in_conditioner;

  localparam int DB = 4;
`ifdef EX_IN_EVENT_LATCH_EN
  localparam logic EVT_EN = 1'b1;
`else
  localparam logic EVT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pin, clr;
  logic [7:0] d_out, d_rise, d_fall, d_evt;
  logic       d_irq;
  logic       chk_en;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_in_conditioner #(
    .FPGAClkSpeed(1000000),
    .DebounceUs  (4),
    .data_width  (8)
  ) dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .ex_data_i (pin),
    .clear_i   (clr),
    .ex_data_o (d_out),
    .rise_o    (d_rise),
    .fall_o    (d_fall),
    .event_o   (d_evt),
    .irq_o     (d_irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a bit's level follows the pin once the pin, seen two edges late,
  // has disagreed with the level for DB consecutive edges.
  logic [7:0] h_new, h_old;
  int         run [8];
  logic [7:0] m_out, m_rise, m_fall, m_evt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h_new  = '0;
      h_old  = '0;
      m_out  = '0;
      m_rise = '0;
      m_fall = '0;
      m_evt  = '0;
      for (int b = 0; b < 8; b++) run[b] = 0;
    end else begin
      m_evt  = (m_evt & ~clr) | m_rise | m_fall;
      m_rise = '0;
      m_fall = '0;
      for (int b = 0; b < 8; b++) begin
        if (h_old[b] != m_out[b]) begin
          run[b]++;
          if (run[b] >= DB) begin
            m_out[b] = h_old[b];
            if (h_old[b]) m_rise[b] = 1'b1;
            else          m_fall[b] = 1'b1;
            run[b] = 0;
          end
        end else begin
          run[b] = 0;
        end
      end
      h_old = h_new;
      h_new = pin;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_lvl",  {24'h0, d_out},  {24'h0, m_out});
      chk("mdl_rise", {24'h0, d_rise}, {24'h0, m_rise});
      chk("mdl_fall", {24'h0, d_fall}, {24'h0, m_fall});
      chk("mdl_evt",  {24'h0, d_evt},  {24'h0, (EVT_EN ? m_evt : 8'h00)});
      chk("mdl_irq",  {31'h0, d_irq},  {31'h0, (EVT_EN ? |m_evt : 1'b0)});
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lvl"},  {24'h0, d_out},  32'h0);
    chk({tag, "_rise"}, {24'h0, d_rise}, 32'h0);
    chk({tag, "_fall"}, {24'h0, d_fall}, 32'h0);
    chk({tag, "_evt"},  {24'h0, d_evt},  32'h0);
    chk({tag, "_irq"},  {31'h0, d_irq},  32'h0);
  endtask

  initial begin
    rst    = 1'b1;
    pin    = '0;
    clr    = '0;
    chk_en = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    // Bit 0 rises: level and pulse on the sixth edge after the change.
    pin = 8'h01;
    repeat (5) @(negedge clk);
    chk("b0_pre", {31'h0, d_out[0]}, 32'h0);
    @(negedge clk);
    chk("b0_lvl",  {31'h0, d_out[0]},  32'h1);
    chk("b0_rise", {31'h0, d_rise[0]}, 32'h1);
    @(negedge clk);
    chk("b0_rise_end", {31'h0, d_rise[0]}, 32'h0);
    chk("b0_evt", {31'h0, d_evt[0]}, {31'h0, EVT_EN});
    chk("b0_irq", {31'h0, d_irq},    {31'h0, EVT_EN});

    // Bit 3 glitch of three cycles is rejected.
    pin = 8'h09;
    repeat (3) @(negedge clk);
    pin = 8'h01;
    repeat (10) @(negedge clk);
    chk("b3_lvl", {31'h0, d_out[3]}, 32'h0);
    chk("b3_evt", {31'h0, d_evt[3]}, 32'h0);

    // Bit 0 falls; clear coincident with the fall pulse loses to the set.
    pin = 8'h00;
    repeat (6) @(negedge clk);
    chk("b0_fall", {31'h0, d_fall[0]}, 32'h1);
    clr = 8'h01;
    @(negedge clk);
    clr = 8'h00;
    chk("b0_set_wins", {31'h0, d_evt[0]}, {31'h0, EVT_EN});
    repeat (2) @(negedge clk);
    clr = 8'h01;
    @(negedge clk);
    clr = 8'h00;
    chk("b0_cleared", {31'h0, d_evt[0]}, 32'h0);
    chk("irq_cleared", {31'h0, d_irq}, 32'h0);

    // All bits at once.
    pin = 8'hA5;
    repeat (5) @(negedge clk);
    chk("a5_pre", {24'h0, d_out}, 32'h0);
    @(negedge clk);
    chk("a5_lvl",  {24'h0, d_out},  32'hA5);
    chk("a5_rise", {24'h0, d_rise}, 32'hA5);
    chk("a5_fall", {24'h0, d_fall}, 32'h0);
    @(negedge clk);
    chk("a5_evt", {24'h0, d_evt}, {24'h0, (EVT_EN ? 8'hA5 : 8'h00)});
    clr = 8'hFF;
    @(negedge clk);
    clr = 8'h00;

    // Reset mid-debounce (counter at 2), asserted between edges.
    pin = 8'hFF;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rel_pre_lvl",  {24'h0, d_out},  32'h0);
    chk("rel_pre_rise", {24'h0, d_rise}, 32'h0);
    @(negedge clk);
    chk("rel_lvl",  {24'h0, d_out},  32'hFF);
    chk("rel_rise", {24'h0, d_rise}, 32'hFF);
    @(negedge clk);
    clr = 8'hFF;
    @(negedge clk);
    clr = 8'h00;

    // Randomized pin traffic with random hold times and clear pulses.
    for (int it = 0; it < 80; it++) begin
      int hold;
      if ($urandom_range(0, 2) == 0) pin = pin ^ (8'h01 << $urandom_range(0, 7));
      else                           pin = 8'($urandom);
      hold = $urandom_range(1, 9);
      for (int c = 0; c < hold; c++) begin
        clr = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
        @(negedge clk);
      end
    end
    clr = 8'h00;
    repeat (12) @(negedge clk);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
